burst_counter: RTL and testbench



---
 rtl/counter_pkg.sv | 18 +
 rtl/edge_detect.sv | 28 ++
 rtl/burst_counter.sv | 124 ++++++++++++
 tb/tb_burst_counter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types and constants for the burst counter and its helpers.
package counter_pkg;

    // Top-level control states.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Encoding of the latched count direction.
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Defaults matching the legacy single-digit 0..9 counter.
    localparam int unsigned WIDTH_DEFAULT = 4;
    localparam int unsigned LIMIT_DEFAULT = 9;

endpackage

// File: rtl/edge_detect.sv
// Two-flop synchroniser followed by a rising-edge detector.
// Produces a single-cycle pulse per low-to-high transition of din,
// two cycles after the transition is first sampled.
module edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic sync1_q, sync2_q, prev_q;

    // Synchronise the asynchronous input and remember its previous value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise = sync2_q & ~prev_q;

endmodule

// File: rtl/burst_counter.sv
// Burst counter: a start request runs a count from S to T, then either stops
// (one-shot) or reloads (repeat). Supports up/down, pause, abort, and
// wrap/done strobes.
// Optional macro BURST_START_EDGE_EN: start is synchronised and edge-detected
// so a held request launches only one burst; otherwise start acts as a level.
module burst_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH     = WIDTH_DEFAULT,
    parameter int unsigned LIMIT_DEF = LIMIT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             pause,
    input  logic             dir_down,
    input  logic             mode_rep,
    input  logic             limit_vld,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] cnt,
    output logic             busy,
    output logic             wrap,
    output logic             done
);

    logic start_req;

`ifdef BURST_START_EDGE_EN
    edge_detect u_start_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (start),
        .rise  (start_req)
    );
`else
    assign start_req = start;
`endif

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] lim_q, lim_d;
    logic             dir_q, dir_d;
    logic             wrap_q, wrap_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] lim_sel;
    logic [WIDTH-1:0] start_val;
    logic [WIDTH-1:0] term_val;

    // Derive the reload and terminal values from the latched burst setup.
    always_comb begin
        lim_sel   = limit_vld ? limit : WIDTH'(LIMIT_DEF);
        start_val = (dir_q == DIR_DOWN) ? lim_q : '0;
        term_val  = (dir_q == DIR_DOWN) ? '0 : lim_q;
    end

    // Next-state, count and strobe logic; abort beats terminal beats step.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lim_d   = lim_q;
        dir_d   = dir_q;
        wrap_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_req && !abort) begin
                    lim_d   = lim_sel;
                    dir_d   = dir_down;
                    cnt_d   = (dir_down == DIR_DOWN) ? lim_sel : '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (!pause) begin
                    if (cnt_q == term_val) begin
                        wrap_d = 1'b1;
                        if (mode_rep) begin
                            cnt_d = start_val;
                        end else begin
                            cnt_d   = '0;
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else if (dir_q == DIR_DOWN) begin
                        cnt_d = cnt_q - WIDTH'(1);
                    end else begin
                        cnt_d = cnt_q + WIDTH'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, count, latched setup and strobe registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lim_q   <= '0;
            dir_q   <= DIR_UP;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lim_q   <= lim_d;
            dir_q   <= dir_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

    assign cnt  = cnt_q;
    assign busy = (state_q == RUN);
    assign wrap = wrap_q;
    assign done = done_q;

endmodule

// File: tb/tb_burst_counter.sv
// Self-checking bench for burst_counter: directed scenarios followed by
// randomized stimulus, compared each cycle against a position-based model.
module tb_burst_counter;

    localparam int unsigned WIDTH     = 4;
    localparam int unsigned LIMIT_DEF = 9;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             pause = 1'b0;
    logic             dir_down = 1'b0;
    logic             mode_rep = 1'b0;
    logic             limit_vld = 1'b0;
    logic [WIDTH-1:0] limit = '0;
    logic [WIDTH-1:0] cnt;
    logic             busy;
    logic             wrap;
    logic             done;

    burst_counter #(
        .WIDTH     (WIDTH),
        .LIMIT_DEF (LIMIT_DEF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .pause     (pause),
        .dir_down  (dir_down),
        .mode_rep  (mode_rep),
        .limit_vld (limit_vld),
        .limit     (limit),
        .cnt       (cnt),
        .busy      (busy),
        .wrap      (wrap),
        .done      (done)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_fail   = 0;
    string phase    = "reset";

    // Reference model: a burst is described by its limit, direction and the
    // number of unpaused steps taken so far (pos, 0..L).
    bit m_busy, m_dir, m_wrap, m_done;
    int m_lim, m_pos;
    bit h1, h2, h3;   // start values seen at the last three edges
    int dut_done_cnt, mdl_done_cnt;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s/%s: got %0d, expected %0d (t=%0t)", phase, tag, obs, exp, $time);
        end
    endtask

    function automatic int m_cnt();
        if (!m_busy) return 0;
        return m_dir ? (m_lim - m_pos) : m_pos;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_dir = 0; m_wrap = 0; m_done = 0;
        m_lim = 0; m_pos = 0;
        h1 = 0; h2 = 0; h3 = 0;
    endtask

    task automatic model_edge();
        bit req;
`ifdef BURST_START_EDGE_EN
        req = h2 && !h3;
`else
        req = start;
`endif
        h3 = h2; h2 = h1; h1 = start;
        m_wrap = 0;
        m_done = 0;
        if (!m_busy) begin
            if (req && !abort) begin
                m_lim  = limit_vld ? int'(limit) : LIMIT_DEF;
                m_dir  = dir_down;
                m_pos  = 0;
                m_busy = 1;
            end
        end else if (abort) begin
            m_busy = 0;
            m_pos  = 0;
        end else if (!pause) begin
            if (m_pos == m_lim) begin
                m_wrap = 1;
                if (mode_rep) m_pos = 0;
                else begin
                    m_busy = 0;
                    m_done = 1;
                    m_pos  = 0;
                end
            end else begin
                m_pos++;
            end
        end
    endtask

    // One clock: update the model on the edge, sample the DUT 1 ns later.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("cnt", int'(cnt), m_cnt());
        check("busy", int'(busy), int'(m_busy));
        check("wrap", int'(wrap), int'(m_wrap));
        check("done", int'(done), int'(m_done));
        dut_done_cnt += int'(done);
        mdl_done_cnt += int'(m_done);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Run until the model reaches a given burst position, within a budget.
    task automatic run_until_pos(input int target, input int budget);
        bit hit = 0;
        for (int i = 0; i < budget && !hit; i++) begin
            tick();
            hit = m_busy && (m_pos == target);
        end
        check("reach_pos", int'(hit), 1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        model_reset();
        #12;
        check("rst_cnt", int'(cnt), 0);
        check("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        ticks(3);

        phase = "oneshot_default";
        limit_vld = 1'b0; limit = 4'd3; dir_down = 1'b0; mode_rep = 1'b0;
        pulse_start();
        ticks(16);

        phase = "down_repeat";
        limit_vld = 1'b1; limit = 4'd3; dir_down = 1'b1; mode_rep = 1'b1;
        pulse_start();
        run_until_pos(2, 20);
        run_until_pos(1, 20);   // into the second burst
        mode_rep = 1'b0;
        ticks(8);

        phase = "pause_abort";
        limit = 4'd9; dir_down = 1'b0;
        pulse_start();
        run_until_pos(4, 20);
        pause = 1'b1;
        ticks(3);
        pause = 1'b0;
        run_until_pos(7, 20);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        ticks(4);

        phase = "limit_zero";
        limit = 4'd0;
        pulse_start();
        ticks(6);

        phase = "start_in_run";
        limit = 4'd5;
        pulse_start();
        ticks(3);
        start = 1'b1;
        ticks(3);
        start = 1'b0;
        ticks(10);

        phase = "start_abort_idle";
        start = 1'b1; abort = 1'b1;
        ticks(4);
        start = 1'b0;
        ticks(2);
        abort = 1'b0;
        ticks(4);

        phase = "held_start";
        dut_done_cnt = 0; mdl_done_cnt = 0;
        start = 1'b1;
        ticks(20);
        start = 1'b0;
        ticks(12);
        check("held_done_count", dut_done_cnt, mdl_done_cnt);
`ifdef BURST_START_EDGE_EN
        check("held_one_burst", dut_done_cnt, 1);
`endif

        phase = "async_reset";
        limit = 4'd9; dir_down = 1'b0;
        pulse_start();
        run_until_pos(5, 20);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_cnt", int'(cnt), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_wrap", int'(wrap), 0);
        check("arst_done", int'(done), 0);
        model_reset();
        rst_n = 1'b1;
        ticks(5);

        phase = "random";
        for (int i = 0; i < 600; i++) begin
            start     = ($urandom_range(0, 3) == 0);
            abort     = ($urandom_range(0, 24) == 0);
            pause     = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 15) == 0) mode_rep = $urandom_range(0, 1) != 0;
            dir_down  = $urandom_range(0, 1) != 0;
            limit_vld = $urandom_range(0, 3) != 0;
            limit     = WIDTH'($urandom_range(0, 15));
            tick();
        end
        start = 1'b0; abort = 1'b0; pause = 1'b0; mode_rep = 1'b0;
        ticks(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
